// File: rtl/seg7_scan_driver.sv
// Multiplexed common-cathode 7-segment driver with refresh divider and frame-synchronous double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 is always shown).
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS=%0d outside 1..8", NUM_DIGITS);
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("seg7_scan_driver: REFRESH_DIV=%0d must be >= 2", REFRESH_DIV);
  end

  // Segment order {a,b,c,d,e,f,g}, 1 = lit.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  wrap_dig;
  logic                  wrap_frm;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] shown;
  logic [3:0]            cur_nib;
  logic                  cur_shown;

  assign wrap_dig = (cnt_q == CNT_LAST);
  assign wrap_frm = wrap_dig && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = wrap_dig ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap_dig) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // disp only moves at the frame boundary, so a frame never mixes old and new digits.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    if (load) begin
      pend_d     = value;
      pend_vld_d = 1'b1;
    end
    if (wrap_frm) begin
      if (load) begin
        disp_d = value;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end
  end

  always_comb begin
    onehot    = '0;
    cur_nib   = 4'h0;
    cur_shown = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        onehot[k] = 1'b1;
        cur_nib   = disp_q[4*k +: 4];
        cur_shown = shown[k];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Walk down from the MS digit; a digit is shown once any nibble at or above it is non-zero.
  always_comb begin
    shown      = '1;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (disp_q[4*k +: 4] == 4'h0);
      shown[k]   = ~upper_zero;
    end
  end
`else
  assign shown = '1;
`endif

  always_comb begin
    seg_d        = cur_shown ? hex7(cur_nib) : 7'b0000000;
    digit_en_d   = blank ? '0 : (onehot & shown);
    frame_tick_d = wrap_frm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      disp_q       <= '0;
      seg_q        <= 7'b0000000;
      digit_en_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      digit_en_q   <= digit_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign digit_en   = digit_en_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed frame-by-frame bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] H0 = 7'b1111110, H1 = 7'b0110000, H2 = 7'b1101101, H3 = 7'b1111001;
  localparam logic [6:0] H4 = 7'b0110011, H5 = 7'b1011011, H6 = 7'b1011111, H7 = 7'b1110000;
  localparam logic [6:0] H8 = 7'b1111111, H9 = 7'b1111011, HA = 7'b1110111, HB = 7'b0011111;
  localparam logic [6:0] HC = 7'b1001110, HD = 7'b0111101, HE = 7'b1001111, HF = 7'b1000111;
  localparam logic [6:0] HX = 7'b0000000;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] S_ZERO = {HX, HX, HX, H0};
  localparam logic [3:0]  M_ZERO = 4'b0001;
  localparam logic [27:0] S_0070 = {HX, HX, H7, H0};
  localparam logic [3:0]  M_0070 = 4'b0011;
`else
  localparam logic [27:0] S_ZERO = {H0, H0, H0, H0};
  localparam logic [3:0]  M_ZERO = 4'b1111;
  localparam logic [27:0] S_0070 = {H0, H0, H7, H0};
  localparam logic [3:0]  M_0070 = 4'b1111;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .blank     (blank),
    .seg       (seg),
    .digit_en  (digit_en),
    .frame_tick(frame_tick)
  );

  // One record per frame: loads/blank issued during it (offset j = captured at edge j of the frame,
  // 0 = unused) and the display expected throughout it. segs = {d3,d2,d1,d0}.
  typedef struct {
    logic [15:0] v1;
    int          o1;
    logic [15:0] v2;
    int          o2;
    int          b_lo;
    int          b_hi;
    logic [27:0] segs;
    logic [3:0]  mask;
  } frame_vec_t;

  frame_vec_t vecs[13];
  frame_vec_t vz;

  function automatic frame_vec_t mk(input logic [15:0] v1, input int o1, input logic [15:0] v2,
                                    input int o2, input int b_lo, input int b_hi,
                                    input logic [27:0] segs, input logic [3:0] mask);
    frame_vec_t r;
    r.v1 = v1; r.o1 = o1; r.v2 = v2; r.o2 = o2;
    r.b_lo = b_lo; r.b_hi = b_hi; r.segs = segs; r.mask = mask;
    return r;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run_frame(input int f, input frame_vec_t v);
    int         d;
    logic       blk;
    logic [3:0] exp_en;
    for (int j = 1; j <= FRAME; j++) begin
      blk   = (j >= v.b_lo) && (j <= v.b_hi);
      load  = (j == v.o1) || (j == v.o2);
      value = (j == v.o2) ? v.v2 : v.v1;
      blank = blk;
      @(posedge clk);
      #1;
      d      = (j - 1) / RD;
      exp_en = 4'b0000;
      if (!blk && v.mask[d]) exp_en[d] = 1'b1;
      check($sformatf("f%0d e%0d seg", f, j), seg, v.segs[7*d +: 7]);
      check($sformatf("f%0d e%0d digit_en", f, j), {3'b000, digit_en}, {3'b000, exp_en});
      check($sformatf("f%0d e%0d frame_tick", f, j), {6'b0, frame_tick}, {6'b0, (j == FRAME)});
    end
    load  = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(16'h1A3F, 2,  16'h0000, 0,  0, -1, S_ZERO,           M_ZERO);
    vecs[1]  = mk(16'h0000, 0,  16'h0000, 0,  0, -1, {H1, HA, H3, HF}, 4'b1111);
    vecs[2]  = mk(16'h1234, 3,  16'h5678, 9,  0, -1, {H1, HA, H3, HF}, 4'b1111);
    vecs[3]  = mk(16'h0000, 0,  16'h0000, 0,  0, -1, {H5, H6, H7, H8}, 4'b1111);
    vecs[4]  = mk(16'hBEEF, 16, 16'h0000, 0,  0, -1, {H5, H6, H7, H8}, 4'b1111);
    vecs[5]  = mk(16'h0000, 0,  16'h0000, 0,  0, -1, {HB, HE, HE, HF}, 4'b1111);
    vecs[6]  = mk(16'h0070, 7,  16'h0000, 0,  0, -1, {HB, HE, HE, HF}, 4'b1111);
    vecs[7]  = mk(16'h0000, 0,  16'h0000, 0,  0, -1, S_0070,           M_0070);
    vecs[8]  = mk(16'h0000, 1,  16'h0000, 0,  0, -1, S_0070,           M_0070);
    vecs[9]  = mk(16'h0000, 0,  16'h0000, 0,  0, -1, S_ZERO,           M_ZERO);
    vecs[10] = mk(16'h0002, 8,  16'h9C4D, 16, 0, -1, S_ZERO,           M_ZERO);
    vecs[11] = mk(16'h0000, 0,  16'h0000, 0,  3, 12, {H9, HC, H4, HD}, 4'b1111);
    vecs[12] = mk(16'h0000, 0,  16'h0000, 0,  0, -1, {H9, HC, H4, HD}, 4'b1111);
    vz       = mk(16'h0000, 0,  16'h0000, 0,  0, -1, S_ZERO,           M_ZERO);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset seg", seg, 7'b0);
    check("reset digit_en", {3'b000, digit_en}, 7'b0);
    check("reset frame_tick", {6'b0, frame_tick}, 7'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < 13; f++) run_frame(f, vecs[f]);

    // Reset mid-scan with a load pending: outputs clear without a clock edge, load is dropped.
    value = 16'h1234;
    for (int j = 1; j <= 6; j++) begin
      load = (j == 3);
      @(posedge clk);
      #1;
    end
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset seg", seg, 7'b0);
    check("midreset digit_en", {3'b000, digit_en}, 7'b0);
    check("midreset frame_tick", {6'b0, frame_tick}, 7'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(13, vz);
    run_frame(14, vz);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
